cpt4_arb: RTL and testbench
===========================

CPT4_ARB -- requirements
Module: cpt4_arb

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock; all state updates on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 REQ  input  4  per-requester request; bit i set = requester i wants a compare.
REQ-005 A  input  16  operand A; requester i drives A[4i+3:4i].
REQ-006 B  input  16  operand B; requester i drives B[4i+3:4i].
REQ-007 GNT  output  4  one-hot grant, held for the whole transaction.
REQ-008 ID  output  2  index of the granted or served requester.
REQ-009 Y  output  1  registered compare result: 1 when latched A > latched B, unsigned 4-bit.
REQ-010 DONE  output  1  one-cycle pulse; Y and ID are valid for the served requester.
REQ-011 BUSY  output  1  high whenever the FSM is not IDLE.

Function
REQ-012 The FSM SHALL have three states: IDLE, CMP and DONE.
REQ-013 In IDLE with REQ != 0, the FSM SHALL select one requester k, set GNT to one-hot k and ID to k, latch A_k and B_k internally, and move to CMP.
REQ-014 In IDLE with REQ == 0, the FSM SHALL stay in IDLE with GNT=0.
REQ-015 In CMP, the FSM SHALL register Y = (A_lat > B_lat), set DONE=1 and move to DONE.
REQ-016 In DONE, the FSM SHALL clear DONE and GNT, hold Y and ID, and return to IDLE.
REQ-017 Latency SHALL be fixed: REQ sampled at edge n gives GNT after edge n, and DONE and Y after edge n+1. Maximum throughput is one transaction per 3 cycles.
REQ-018 A requester SHALL hold its operands stable until its GNT rises; operands are latched at the grant edge, and later operand changes SHALL NOT affect Y.
REQ-019 Deasserting REQ after the grant SHALL NOT abort the transaction; DONE still pulses.
REQ-020 A requester still asserting REQ in IDLE after its DONE SHALL be treated as a new request.
REQ-021 Round-robin rule: a 2-bit pointer PTR gives search order PTR, PTR+1, PTR+2, PTR+3 (mod 4); the first set REQ bit wins.
REQ-022 After granting k, PTR SHALL become (k+1) mod 4.
REQ-023 Equal operands (A == B) SHALL give Y=0.
REQ-024 Boundary operands (A=15, B=0) SHALL give Y=1, and (A=0, B=15) SHALL give Y=0.
REQ-025 GNT SHALL never have more than one bit set.

Reset
REQ-026 While rst is high at a clock edge, the block SHALL go to IDLE with PTR=0, GNT=0, ID=0, Y=0, DONE=0 and BUSY=0.
REQ-027 A reset asserted in CMP or DONE SHALL abort the transaction with no DONE pulse; pending REQ is re-arbitrated from PTR=0 after rst falls.

Configuration
REQ-028 With macro CPT4_ARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority: the lowest set index wins and PTR is unused.
REQ-029 With CPT4_ARB_FIXED_PRIO_EN undefined, arbitration SHALL be round-robin per REQ-021 and REQ-022.

Verification
REQ-030 Single request: REQ=0001, A[3:0]=9, B[3:0]=4 -> GNT=0001 after 1 cycle; DONE=1, Y=1, ID=0 after 2 cycles; BUSY low after 3 cycles.
REQ-031 Equal and edge operands: requester 2 with A=7, B=7 -> Y=0; then A=0, B=15 -> Y=0; then A=15, B=0 -> Y=1.
REQ-032 Contention (round-robin build): REQ=1111 held from reset -> grant order 0,1,2,3,0, with DONE every 3 cycles. With CPT4_ARB_FIXED_PRIO_EN -> grants 0,0,0...
REQ-033 Operand change after grant: requester 1 with A=3, B=5 granted, then A changed to 12 during CMP -> Y=0.
REQ-034 Withdraw and reset: REQ drops during CMP -> DONE still pulses. In a second run, rst asserted in CMP -> no DONE, all outputs 0 next cycle, and the next grant follows PTR=0.

Source files
------------

// File: rtl/cpt4_arb_if.sv
// rtl/cpt4_arb_if.sv - request/operand/result bundle for the 4-requester compare arbiter
//
// Signals:
//   REQ  [3:0]  per-requester request, bit i = requester i
//   A    [15:0] operand A, requester i drives A[4i+3:4i]
//   B    [15:0] operand B, requester i drives B[4i+3:4i]
//   GNT  [3:0]  one-hot grant, held for the whole transaction
//   ID   [1:0]  index of the granted / served requester
//   Y           registered result, latched A > latched B (unsigned)
//   DONE        one-cycle pulse when Y and ID are valid
//   BUSY        high whenever the arbiter is not idle
// Modports: master = requester side, slave = arbiter side.
interface cpt4_arb_if;
  logic [3:0]  REQ;
  logic [15:0] A;
  logic [15:0] B;
  logic [3:0]  GNT;
  logic [1:0]  ID;
  logic        Y;
  logic        DONE;
  logic        BUSY;

  modport master (
    output REQ, A, B,
    input  GNT, ID, Y, DONE, BUSY
  );

  modport slave (
    input  REQ, A, B,
    output GNT, ID, Y, DONE, BUSY
  );
endinterface

// File: rtl/cpt4_arb.sv
// rtl/cpt4_arb.sv - 4-requester arbiter serving one unsigned 4-bit A > B compare per grant
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  cpt4_arb_if.slave (REQ/A/B in, GNT/ID/Y/DONE/BUSY out)
// Configuration:
//   CPT4_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest set REQ index wins
//                           undefined -> round-robin from a 2-bit pointer
// Timing: REQ sampled at edge n -> GNT/ID after edge n, DONE/Y after edge n+1,
//         back to idle after edge n+2 (one transaction per 3 cycles).
module cpt4_arb (
  input  logic      clk,
  input  logic      rst,
  cpt4_arb_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  gnt_q,   gnt_d;
  logic [1:0]  id_q,    id_d;
  logic        y_q,     y_d;
  logic        done_q,  done_d;
  logic [3:0]  a_lat_q, a_lat_d;
  logic [3:0]  b_lat_q, b_lat_d;

  logic        req_any;
  logic [1:0]  win;
  logic        grant_now;

  assign req_any   = |bus.REQ;
  assign grant_now = (state_q == ST_IDLE) && req_any;

  // Winner selection. Both loops scan from the least preferred candidate
  // to the most preferred, so the last hit is the one that sticks.
`ifdef CPT4_ARB_FIXED_PRIO_EN
  always_comb begin
    win = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (bus.REQ[i]) win = 2'(i);
    end
  end
`else
  logic [1:0] ptr_q;
  logic [1:0] cand;

  always_comb begin
    win  = 2'd0;
    cand = 2'd0;
    for (int off = 3; off >= 0; off--) begin
      cand = ptr_q + 2'(off);
      if (bus.REQ[cand]) win = cand;
    end
  end

  // Pointer moves just past the requester that was granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 2'd0;
    end else if (grant_now) begin
      ptr_q <= win + 2'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= 4'd0;
      id_q    <= 2'd0;
      y_q     <= 1'b0;
      done_q  <= 1'b0;
      a_lat_q <= 4'd0;
      b_lat_q <= 4'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      y_q     <= y_d;
      done_q  <= done_d;
      a_lat_q <= a_lat_d;
      b_lat_q <= b_lat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    y_d     = y_q;
    done_d  = 1'b0;
    a_lat_d = a_lat_q;
    b_lat_d = b_lat_q;

    case (state_q)
      ST_IDLE: begin
        gnt_d = 4'd0;
        if (req_any) begin
          gnt_d   = 4'b0001 << win;
          id_d    = win;
          // Operands are captured at the grant edge; later changes are ignored.
          a_lat_d = bus.A[{win, 2'b00} +: 4];
          b_lat_d = bus.B[{win, 2'b00} +: 4];
          state_d = ST_CMP;
        end
      end
      ST_CMP: begin
        y_d     = (a_lat_q > b_lat_q);
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        gnt_d   = 4'd0;
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = 4'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.GNT  = gnt_q;
  assign bus.ID   = id_q;
  assign bus.Y    = y_q;
  assign bus.DONE = done_q;
  assign bus.BUSY = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cpt4_arb.sv
// tb/tb_cpt4_arb.sv - directed self-checking bench for cpt4_arb
module tb_cpt4_arb;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  cpt4_arb_if bus ();

  cpt4_arb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full transaction; REQ withdrawn during CMP, optional operand poke after grant.
  task automatic run_txn(input string tag, input logic [3:0] req, input int exp_k,
                         input logic exp_y, input bit poke, input logic [3:0] poke_a);
    logic [3:0] exp_gnt;
    exp_gnt = 4'b0001 << exp_k;
    bus.REQ = req;
    tick();
    check_eq({tag, "_gnt"},  16'(bus.GNT),  16'(exp_gnt));
    check_eq({tag, "_id"},   16'(bus.ID),   16'(exp_k));
    check_eq({tag, "_busy"}, 16'(bus.BUSY), 16'd1);
    check_eq({tag, "_done0"}, 16'(bus.DONE), 16'd0);
    bus.REQ = 4'd0;
    if (poke) bus.A[4*exp_k +: 4] = poke_a;
    tick();
    check_eq({tag, "_done"}, 16'(bus.DONE), 16'd1);
    check_eq({tag, "_y"},    16'(bus.Y),    16'(exp_y));
    check_eq({tag, "_id2"},  16'(bus.ID),   16'(exp_k));
    tick();
    check_eq({tag, "_done_clr"}, 16'(bus.DONE), 16'd0);
    check_eq({tag, "_gnt_clr"},  16'(bus.GNT),  16'd0);
    check_eq({tag, "_idle"},     16'(bus.BUSY), 16'd0);
    check_eq({tag, "_y_hold"},   16'(bus.Y),    16'(exp_y));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_k;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.REQ  = 4'd0;
    bus.A    = 16'd0;
    bus.B    = 16'd0;
    tick();
    tick();
    check_eq("rst_gnt",  16'(bus.GNT),  16'd0);
    check_eq("rst_id",   16'(bus.ID),   16'd0);
    check_eq("rst_y",    16'(bus.Y),    16'd0);
    check_eq("rst_done", 16'(bus.DONE), 16'd0);
    check_eq("rst_busy", 16'(bus.BUSY), 16'd0);
    rst = 1'b0;

    // Single request: 9 > 4.
    bus.A[3:0] = 4'd9;
    bus.B[3:0] = 4'd4;
    run_txn("single", 4'b0001, 0, 1'b1, 1'b0, 4'd0);

    // Equal and edge operands on requester 2.
    bus.A[11:8] = 4'd7;  bus.B[11:8] = 4'd7;
    run_txn("eq", 4'b0100, 2, 1'b0, 1'b0, 4'd0);
    bus.A[11:8] = 4'd0;  bus.B[11:8] = 4'd15;
    run_txn("a0_b15", 4'b0100, 2, 1'b0, 1'b0, 4'd0);
    bus.A[11:8] = 4'd15; bus.B[11:8] = 4'd0;
    run_txn("a15_b0", 4'b0100, 2, 1'b1, 1'b0, 4'd0);

    // No request: stays idle.
    tick();
    check_eq("noreq_gnt",  16'(bus.GNT),  16'd0);
    check_eq("noreq_busy", 16'(bus.BUSY), 16'd0);

    // Requester 1: 3 vs 5, A raised to 12 during CMP must not matter.
    bus.A[7:4] = 4'd3;
    bus.B[7:4] = 4'd5;
    run_txn("late_a", 4'b0010, 1, 1'b0, 1'b1, 4'd12);

    // Contention from reset with all four requesting.
    rst     = 1'b1;
    bus.A   = 16'h0F0F;
    bus.B   = 16'hF0F0;
    bus.REQ = 4'b1111;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
`ifdef CPT4_ARB_FIXED_PRIO_EN
      exp_k = 0;
`else
      exp_k = i % 4;
`endif
      tick();
      check_eq($sformatf("cont%0d_gnt", i), 16'(bus.GNT), 16'(4'b0001 << exp_k));
      check_eq($sformatf("cont%0d_id", i),  16'(bus.ID),  16'(exp_k));
      tick();
      check_eq($sformatf("cont%0d_done", i), 16'(bus.DONE), 16'd1);
      check_eq($sformatf("cont%0d_y", i),    16'(bus.Y),    16'((exp_k % 2) == 0));
      tick();
      check_eq($sformatf("cont%0d_done_clr", i), 16'(bus.DONE), 16'd0);
    end
    bus.REQ = 4'd0;
    tick();
    tick();
    tick();

    // Reset during CMP aborts; re-arbitration restarts from pointer 0.
    bus.REQ = 4'b0010;
    tick();
    check_eq("rcmp_gnt", 16'(bus.GNT), 16'b0010);
    rst     = 1'b1;
    bus.REQ = 4'b1010;
    tick();
    check_eq("rcmp_gnt0", 16'(bus.GNT),  16'd0);
    check_eq("rcmp_done", 16'(bus.DONE), 16'd0);
    check_eq("rcmp_busy", 16'(bus.BUSY), 16'd0);
    check_eq("rcmp_id",   16'(bus.ID),   16'd0);
    check_eq("rcmp_y",    16'(bus.Y),    16'd0);
    rst = 1'b0;
    tick();
    check_eq("rcmp_regnt", 16'(bus.GNT), 16'b0010);
    check_eq("rcmp_reid",  16'(bus.ID),  16'd1);
    bus.REQ = 4'd0;
    tick();
    check_eq("rcmp_redone", 16'(bus.DONE), 16'd1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
